// File: rtl/uart_rx_deserializer_if.sv
// Serial receive bundle: rxd line in, recovered byte and status strobes out.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rxd,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: double-synchronised rxd, mid-bit sampling with a fixed
// oversampling count, one-cycle rx_valid / frame_err strobes.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_rx_deserializer_if.slave   rx
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rxd_m, rxd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rx.rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                cnt_d = cnt_q + CW'(1);
                // Re-check the start bit at its middle; a short low glitch falls back to idle.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shreg_d = DATA_BITS'({rxd_s, shreg_q} >> 1);
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IX) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end
            end

            // Hold here through a break so it reports a single frame error.
            RECOVER: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: table of single frames plus
// hand-written back-to-back, glitch, break, reset and jitter sequences.
module tb_uart_rx_deserializer;
    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int LAT = 155;   // rxd falling edge to rx_valid seen at negedge

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_deserializer_if #(.DATA_BITS(DB)) bus ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[6];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         ferr_n      = 0;
    int         both_n      = 0;
    logic [7:0] vq[$];
    int         vcyc[$];
    int         jit[11];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            vq.push_back(bus.rx_data);
            vcyc.push_back(cyc);
        end
        if (bus.frame_err) ferr_n++;
        if (bus.rx_valid && bus.frame_err) both_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int st);
        st = cyc;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
        send_bit(stop, CPB);
    endtask

    task automatic send_frame_jit(input logic [7:0] d, output int st);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        st = cyc;
        for (int k = 0; k < 10; k++) send_bit(bits[k], CPB + jit[k+1] - jit[k]);
    endtask

    initial begin
        int st, st2, nv0, nf0, bc;

        tbl[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        tbl[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        tbl[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
        tbl[4] = '{8'hC4, 1'b0, 0, 1, 8'h81};
        tbl[5] = '{8'h55, 1'b1, 1, 0, 8'h55};
        jit = '{0, 3, -3, 2, -2, 3, -1, -3, 1, 2, 0};

        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rx_data", bus.rx_data, 0);
        check("reset_rx_valid", bus.rx_valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            nv0 = vq.size();
            nf0 = ferr_n;
            send_bit(1'b1, 20);
            send_frame(tbl[v].d, tbl[v].stop, st);
            send_bit(1'b1, 30);
            #1;
            check($sformatf("tbl%0d_valid_count", v), vq.size() - nv0, tbl[v].exp_valid);
            check($sformatf("tbl%0d_ferr_count", v), ferr_n - nf0, tbl[v].exp_ferr);
            check($sformatf("tbl%0d_rx_data", v), bus.rx_data, tbl[v].exp_data);
            check($sformatf("tbl%0d_busy", v), bus.busy, 0);
            if (tbl[v].exp_valid == 1 && vq.size() > nv0) begin
                check($sformatf("tbl%0d_pulse_data", v), vq[nv0], tbl[v].exp_data);
                check($sformatf("tbl%0d_latency", v), vcyc[nv0] - st, LAT);
            end
        end

        // Break: bad stop bit then line held low.
        nv0 = vq.size();
        nf0 = ferr_n;
        send_bit(1'b1, 20);
        send_frame(8'hFF, 1'b0, st);
        send_bit(1'b0, 64);
        #1;
        check("break_ferr_count", ferr_n - nf0, 1);
        check("break_valid_count", vq.size() - nv0, 0);
        check("break_busy_held", bus.busy, 1);
        check("break_rx_data", bus.rx_data, 8'h55);
        send_bit(1'b1, 30);
        #1;
        check("break_busy_after", bus.busy, 0);
        check("break_ferr_final", ferr_n - nf0, 1);
        check("break_valid_final", vq.size() - nv0, 0);

        // Back-to-back frames with no idle bits.
        nv0 = vq.size();
        send_bit(1'b1, 20);
        send_frame(8'hA3, 1'b1, st);
        send_frame(8'h0F, 1'b1, st2);
        send_bit(1'b1, 30);
        #1;
        check("b2b_valid_count", vq.size() - nv0, 2);
        if (vq.size() - nv0 == 2) begin
            check("b2b_first", vq[nv0], 8'hA3);
            check("b2b_second", vq[nv0+1], 8'h0F);
            check("b2b_spacing", vcyc[nv0+1] - vcyc[nv0], 160);
        end
        check("b2b_rx_data", bus.rx_data, 8'h0F);

        // Start-bit glitch of 4 cycles.
        nv0 = vq.size();
        nf0 = ferr_n;
        send_bit(1'b1, 20);
        bus.rxd = 1'b0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) bus.rxd = 1'b1;
            @(negedge clk);
            if (bus.busy) bc++;
        end
        #1;
        check("glitch_busy_le8", (bc <= 8), 1);
        check("glitch_busy_seen", (bc >= 1), 1);
        check("glitch_no_valid", vq.size() - nv0, 0);
        check("glitch_no_ferr", ferr_n - nf0, 0);
        check("glitch_idle", bus.busy, 0);
        check("glitch_rx_data", bus.rx_data, 8'h0F);

        // Jittered bit edges.
        nv0 = vq.size();
        send_bit(1'b1, 20);
        send_frame_jit(8'h96, st);
        send_bit(1'b1, 30);
        #1;
        check("jitter_valid_count", vq.size() - nv0, 1);
        check("jitter_rx_data", bus.rx_data, 8'h96);

        // Reset during the 4th data bit.
        send_bit(1'b1, 20);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, 8);
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rx_data", bus.rx_data, 0);
        check("midrst_rx_valid", bus.rx_valid, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_busy", bus.busy, 0);
        bus.rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        nv0 = vq.size();
        nf0 = ferr_n;
        send_bit(1'b1, 20);
        send_frame(8'h3C, 1'b1, st);
        send_bit(1'b1, 30);
        #1;
        check("postrst_valid_count", vq.size() - nv0, 1);
        check("postrst_ferr_count", ferr_n - nf0, 0);
        check("postrst_rx_data", bus.rx_data, 8'h3C);

        check("valid_ferr_exclusive", both_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
